utlb_cache: RTL and testbench
=============================

UTLB_CACHE -- requirements
Module: utlb_cache

Interface
REQ-001 SHALL take parameter ENTRIES, default 4, meaning the number of micro-TLB entries (power of two, 2..16).
REQ-002 SHALL take parameter INDEX_W, default 4, meaning the width of the main-TLB index.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port va, input, 32, the virtual address being translated.
REQ-006 SHALL have port use_tlb, input, 1, high when va is mapped and needs translation.
REQ-007 SHALL have port asid, input, 8, the current EntryHi ASID.
REQ-008 SHALL have port addr_ok, input, 1, downstream accepted the request.
REQ-009 SHALL have port tlb_exception, input, 1, downstream raised a TLB exception for this request.
REQ-010 SHALL have port tlb_write, input, 1, main TLB is being written (flush request).
REQ-011 SHALL have port s_vpn2, output, 19, main-TLB search VPN2; always equals va[31:13].
REQ-012 SHALL have port s_odd, output, 1, main-TLB search odd-page bit; always equals va[12].
REQ-013 SHALL have ports s_index (input, INDEX_W), s_found, s_d, s_v (input, 1 each) and s_pfn (input, 20), the main-TLB search result.
REQ-014 SHALL have port req_en, output, 1, high when the request may proceed to memory.
REQ-015 SHALL have ports out_pfn (output, 20), out_index (output, INDEX_W) and out_found, out_v, out_d (output, 1 each), the translation result.
REQ-016 SHALL have port miss_cnt, output, 16, the count of micro-TLB misses.

Function
REQ-017 Each entry SHALL hold: valid, vpn2[18:0], odd, asid[7:0], pfn, index, found, v, d.
REQ-018 Entry hit condition: valid & vpn2==va[31:13] & odd==va[12] (plus ASID match per REQ-032).
- If several entries hit, the lowest-numbered entry SHALL win.
REQ-019 FSM SHALL have three states: IDLE=00, LOOKUP=01, WAIT=10; encoding 11 SHALL return to IDLE.
REQ-020 IDLE -> LOOKUP when use_tlb & !hit; otherwise remain in IDLE.
REQ-021 LOOKUP SHALL last exactly one cycle, then go to WAIT.
REQ-022 WAIT -> IDLE when addr_ok | tlb_exception; otherwise remain in WAIT.
REQ-023 In LOOKUP, the block SHALL:
- write s_* plus va fields and asid into the entry at the round-robin pointer, with valid=1;
- copy the same data into a result register;
- advance the pointer modulo ENTRIES;
- increment miss_cnt, wrapping at 16'hFFFF->0.
REQ-024 req_en SHALL be ((hit | !use_tlb) & IDLE) | WAIT.
- Hit latency: 0 cycles.
- Miss: req_en rises 2 cycles after the miss cycle.
REQ-025 Output source by state:
- IDLE: outputs SHALL come combinationally from the hitting entry, or all zero if there is no hit.
- LOOKUP and WAIT: outputs SHALL come from the result register.
REQ-026 tlb_write SHALL clear every valid bit at the next edge.
- If it coincides with a LOOKUP fill, the clear wins: the filled entry stays invalid.
- The result register SHALL still load, and WAIT completes normally.
REQ-027 tlb_write SHALL NOT change the FSM state or the round-robin pointer.
REQ-028 While a request is outstanding, va SHALL be held stable by the requester. The block does not check this.

Reset
REQ-029 On reset the block SHALL clear:
- FSM to IDLE;
- all valid bits, the pointer, the result register and miss_cnt to 0.
REQ-030 Therefore outputs after reset SHALL be req_en = !use_tlb, with out_pfn, out_index, out_found, out_v and out_d all 0.
REQ-031 Reset mid-LOOKUP or mid-WAIT SHALL abandon the request with no entry written.

Configuration
REQ-032 Macro UTLB_ASID_EN:
- Defined: the hit condition SHALL additionally require entry.asid==asid; the stored asid is used.
- Undefined: ASID SHALL be ignored for hit, and any change of asid between consecutive cycles SHALL flush all entries exactly as tlb_write does.

Verification
REQ-033 Miss then hit: after reset, va=0x00402000 with use_tlb=1 and s_pfn=0x12345, s_found=1 -> req_en=0 for 2 cycles, then 1; out_pfn=0x12345; addr_ok returns to IDLE. Same va again -> req_en=1 the same cycle; miss_cnt=1.
REQ-034 Round-robin eviction: ENTRIES=4, five distinct VPN2 misses -> entry 0 is overwritten. The first va misses again, giving miss_cnt=6.
REQ-035 Flush: fill 2 entries, pulse tlb_write -> both va miss again. tlb_write during LOOKUP -> the entry is not retained, and WAIT still outputs the looked-up pfn.
REQ-036 Exception exit: in WAIT, tlb_exception=1 with addr_ok=0 -> IDLE next cycle.
REQ-037 Unmapped: use_tlb=0 with any va -> req_en=1 in IDLE, no LOOKUP, miss_cnt unchanged.
REQ-038 ASID: fill va 0x80001000 with asid=5, then change asid to 6.
- UTLB_ASID_EN defined: miss.
- UTLB_ASID_EN undefined: flush, then miss; both cases give miss_cnt=2.

Source files
------------

// File: rtl/utlb_cache.sv
// utlb_cache: micro-TLB in front of the main TLB, round-robin fill, optional ASID tagging (UTLB_ASID_EN)
module utlb_cache #(
  parameter int ENTRIES = 4,
  parameter int INDEX_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        va,
  input  logic               use_tlb,
  input  logic [7:0]         asid,
  input  logic               addr_ok,
  input  logic               tlb_exception,
  input  logic               tlb_write,
  output logic [18:0]        s_vpn2,
  output logic               s_odd,
  input  logic [INDEX_W-1:0] s_index,
  input  logic               s_found,
  input  logic               s_d,
  input  logic               s_v,
  input  logic [19:0]        s_pfn,
  output logic               req_en,
  output logic [19:0]        out_pfn,
  output logic [INDEX_W-1:0] out_index,
  output logic               out_found,
  output logic               out_v,
  output logic               out_d,
  output logic [15:0]        miss_cnt
);
  localparam int PW = $clog2(ENTRIES);
  typedef struct packed {
    logic [19:0]        pfn;
    logic [INDEX_W-1:0] index;
    logic               found;
    logic               v;
    logic               d;
  } res_t;
  typedef struct packed {
    logic [18:0] vpn2;
    logic        odd;
`ifdef UTLB_ASID_EN
    logic [7:0]  asid;
`endif
    res_t        res;
  } ent_t;
  typedef enum logic [1:0] {IDLE = 2'b00, LOOKUP = 2'b01, WAIT = 2'b10} state_t;
  state_t             state, state_nxt;
  logic [ENTRIES-1:0] valid;
  ent_t               ent [ENTRIES];
  ent_t               fill;
  logic [PW-1:0]      ptr;
  res_t               res_q, hit_res, out;
  logic               hit, flush;
  assign s_vpn2 = va[31:13];
  assign s_odd  = va[12];
  assign fill.vpn2 = va[31:13];
  assign fill.odd  = va[12];
`ifdef UTLB_ASID_EN
  assign fill.asid = asid;
  assign flush = tlb_write;
`else
  logic [7:0] asid_q;
  assign flush = tlb_write | (asid != asid_q);
  // previous-cycle asid, so that any change flushes the entries
  always_ff @(posedge clk) asid_q <= asid;
`endif
  assign fill.res = '{pfn: s_pfn, index: s_index, found: s_found, v: s_v, d: s_d};
  // hit search; scanning downward lets the lowest-numbered hitting entry win
  always_comb begin
    hit = 1'b0;
    hit_res = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (valid[i] && ent[i].vpn2 == va[31:13] && ent[i].odd == va[12]
`ifdef UTLB_ASID_EN
          && ent[i].asid == asid
`endif
         ) begin
        hit = 1'b1;
        hit_res = ent[i].res;
      end
  end
  // next state; the unused 11 encoding falls back to IDLE
  always_comb begin
    state_nxt = IDLE;
    state_nxt = (state == IDLE)   ? ((use_tlb && !hit) ? LOOKUP : IDLE) :
                (state == LOOKUP) ? WAIT :
                (state == WAIT && !(addr_ok || tlb_exception)) ? WAIT : IDLE;
  end
  // control state: FSM, valid bits, fill pointer, result register, miss counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= '0;
      ptr      <= '0;
      res_q    <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nxt;
      valid <= flush ? '0 : (state == LOOKUP) ? (valid | (ENTRIES'(1) << ptr)) : valid;
      if (state == LOOKUP) begin
        res_q    <= fill.res;
        ptr      <= ptr + PW'(1);
        miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
  // entry payload, written at the round-robin slot when a lookup completes
  always_ff @(posedge clk) begin
    if (!reset && state == LOOKUP) ent[ptr] <= fill;
  end
  assign out = (state == IDLE) ? hit_res : res_q;
  assign {out_pfn, out_index, out_found, out_v, out_d} = out;
  assign req_en = ((hit || !use_tlb) && state == IDLE) || state == WAIT;
endmodule

// File: tb/tb_utlb_cache.sv
// tb_utlb_cache: directed checks of miss/hit, eviction, flush, exception exit, ASID and reset abort
module tb_utlb_cache;
  logic        clk = 1'b0;
  logic        reset, use_tlb, addr_ok, tlb_exception, tlb_write;
  logic [31:0] va;
  logic [7:0]  asid;
  logic [18:0] s_vpn2;
  logic        s_odd, s_found, s_d, s_v, req_en, out_found, out_v, out_d;
  logic [3:0]  s_index, out_index;
  logic [19:0] s_pfn, out_pfn;
  logic [15:0] miss_cnt;
  int          n_chk = 0, n_fail = 0;

  utlb_cache #(.ENTRIES(4), .INDEX_W(4)) dut (
    .clk(clk), .reset(reset), .va(va), .use_tlb(use_tlb), .asid(asid),
    .addr_ok(addr_ok), .tlb_exception(tlb_exception), .tlb_write(tlb_write),
    .s_vpn2(s_vpn2), .s_odd(s_odd), .s_index(s_index), .s_found(s_found),
    .s_d(s_d), .s_v(s_v), .s_pfn(s_pfn), .req_en(req_en), .out_pfn(out_pfn),
    .out_index(out_index), .out_found(out_found), .out_v(out_v), .out_d(out_d),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // full miss sequence for address a, main TLB answering with pfn p
  task automatic fill(input logic [31:0] a, input logic [19:0] p);
    va = a; use_tlb = 1'b1; s_pfn = p; s_index = p[3:0]; s_found = 1'b1; s_v = 1'b1; s_d = 1'b0;
    #1 chk("miss_req_en", {31'b0, req_en}, 0);
    tick();
    chk("lookup_req_en", {31'b0, req_en}, 0);
    tick();
    s_pfn = ~p;
    #1 chk("wait_req_en", {31'b0, req_en}, 1);
    chk("wait_pfn", {12'b0, out_pfn}, {12'b0, p});
    chk("wait_found", {31'b0, out_found}, 1);
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; s_pfn = 20'h0;
    #1 chk("hit_req_en", {31'b0, req_en}, 1);
    chk("hit_pfn", {12'b0, out_pfn}, {12'b0, p});
  endtask

  initial begin
    reset = 1'b1; use_tlb = 1'b1; va = 32'h0; asid = 8'h0; addr_ok = 1'b0;
    tlb_exception = 1'b0; tlb_write = 1'b0; s_index = 4'h0; s_found = 1'b0;
    s_d = 1'b0; s_v = 1'b0; s_pfn = 20'h0;
    tick(); tick();
    chk("rst_req_en_mapped", {31'b0, req_en}, 0);
    chk("rst_pfn", {12'b0, out_pfn}, 0);
    chk("rst_found", {31'b0, out_found}, 0);
    chk("rst_miss_cnt", {16'b0, miss_cnt}, 0);
    use_tlb = 1'b0;
    #1 chk("rst_req_en_unmapped", {31'b0, req_en}, 1);
    tick();
    reset = 1'b0;
    va = 32'h0040_2000;
    #1 chk("s_vpn2", {13'b0, s_vpn2}, 32'h201);
    chk("s_odd", {31'b0, s_odd}, 0);
    // miss then hit
    fill(32'h0040_2000, 20'h12345);
    chk("miss_cnt_1", {16'b0, miss_cnt}, 1);
    tick();
    chk("hit_stays_idle_cnt", {16'b0, miss_cnt}, 1);
    chk("hit_again_req_en", {31'b0, req_en}, 1);
    // unmapped access: no lookup, counter unchanged
    use_tlb = 1'b0; va = 32'h1234_5000;
    #1 chk("unmapped_req_en", {31'b0, req_en}, 1);
    chk("unmapped_nohit_pfn", {12'b0, out_pfn}, 0);
    tick(); tick();
    chk("unmapped_cnt", {16'b0, miss_cnt}, 1);
    chk("unmapped_req_en2", {31'b0, req_en}, 1);
    // round-robin eviction: the fifth distinct fill overwrites entry 0
    fill(32'h0040_4000, 20'h11111);
    fill(32'h0040_6000, 20'h22222);
    fill(32'h0040_8000, 20'h33333);
    fill(32'h0040_A000, 20'h44444);
    chk("rr_cnt_5", {16'b0, miss_cnt}, 5);
    fill(32'h0040_2000, 20'h55555);
    chk("rr_cnt_6", {16'b0, miss_cnt}, 6);
    use_tlb = 1'b0; va = 32'h0040_6000;
    #1 chk("rr_keep_pfn", {12'b0, out_pfn}, 32'h22222);
    chk("pre_flush_found_a", {31'b0, out_found}, 1);
    va = 32'h0040_8000;
    #1 chk("pre_flush_found_b", {31'b0, out_found}, 1);
    // flush
    tlb_write = 1'b1;
    tick();
    tlb_write = 1'b0;
    #1 chk("flush_found_b", {31'b0, out_found}, 0);
    va = 32'h0040_6000;
    #1 chk("flush_found_a", {31'b0, out_found}, 0);
    use_tlb = 1'b1;
    #1 chk("flush_miss_req_en", {31'b0, req_en}, 0);
    use_tlb = 1'b0;
    // flush coinciding with the fill
    va = 32'h0050_0000; use_tlb = 1'b1; s_pfn = 20'h77777; s_found = 1'b1;
    #1 chk("wfill_miss", {31'b0, req_en}, 0);
    tick();
    tlb_write = 1'b1;
    tick();
    tlb_write = 1'b0;
    chk("wfill_wait_req_en", {31'b0, req_en}, 1);
    chk("wfill_wait_pfn", {12'b0, out_pfn}, 32'h77777);
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; use_tlb = 1'b0;
    #1 chk("wfill_not_retained", {31'b0, out_found}, 0);
    chk("wfill_idle_req_en", {31'b0, req_en}, 1);
    chk("wfill_cnt", {16'b0, miss_cnt}, 7);
    // exception exit from WAIT
    va = 32'h0060_0000; use_tlb = 1'b1; s_pfn = 20'h88888;
    tick(); tick();
    chk("exc_wait_req_en", {31'b0, req_en}, 1);
    tick();
    chk("exc_wait_hold", {31'b0, req_en}, 1);
    chk("exc_wait_pfn", {12'b0, out_pfn}, 32'h88888);
    tlb_exception = 1'b1;
    tick();
    tlb_exception = 1'b0; va = 32'h0070_0000;
    #1 chk("exc_idle_miss", {31'b0, req_en}, 0);
    use_tlb = 1'b0; va = 32'h0060_0000;
    #1 chk("exc_entry_pfn", {12'b0, out_pfn}, 32'h88888);
    chk("exc_cnt", {16'b0, miss_cnt}, 8);
    // ASID change
    reset = 1'b1;
    tick();
    reset = 1'b0; asid = 8'd5;
    tick();
    chk("asid_rst_cnt", {16'b0, miss_cnt}, 0);
    fill(32'h8000_1000, 20'h9ABCD);
    chk("asid_s_odd", {31'b0, s_odd}, 1);
    asid = 8'd6; use_tlb = 1'b0;
`ifdef UTLB_ASID_EN
    #1 chk("asid_change_found", {31'b0, out_found}, 0);
`else
    #1 chk("asid_change_found", {31'b0, out_found}, 1);
`endif
    tick();
    chk("asid_after_found", {31'b0, out_found}, 0);
    fill(32'h8000_1000, 20'h0BEEF);
    chk("asid_cnt_2", {16'b0, miss_cnt}, 2);
    // reset in LOOKUP abandons the request
    va = 32'hC000_0000; use_tlb = 1'b1; s_pfn = 20'h0CAFE;
    tick();
    reset = 1'b1; use_tlb = 1'b0;
    tick();
    reset = 1'b0;
    #1 chk("rst_abort_found", {31'b0, out_found}, 0);
    chk("rst_abort_cnt", {16'b0, miss_cnt}, 0);
    chk("rst_abort_req_en", {31'b0, req_en}, 1);
    tick();
    chk("rst_abort_cnt2", {16'b0, miss_cnt}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
